// File: rtl/board_pkg.sv
// Shared definitions for the Othello board-memory endpoint: cell encodings,
// client owner IDs, board geometry and small helper functions.
package board_pkg;

    localparam int BOARD_CELLS = 64;
    localparam int ADDR_W      = 7;
    localparam int COUNT_W     = 7;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_RSVD  = 2'b11;

    localparam logic [1:0] OWN_INIT = 2'd0;
    localparam logic [1:0] OWN_VALI = 2'd1;
    localparam logic [1:0] OWN_FLIP = 2'd2;
    localparam logic [1:0] OWN_VGA  = 2'd3;

    localparam logic [COUNT_W-1:0] COUNT_MAX = 7'd64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } resp_state_e;

    function automatic logic [3:0] owner_onehot(input logic [1:0] owner);
        logic [3:0] oh;
        case (owner)
            OWN_INIT: oh = 4'b0001;
            OWN_VALI: oh = 4'b0010;
            OWN_FLIP: oh = 4'b0100;
            OWN_VGA:  oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // A simultaneous increment and decrement cancel, which is how a same-colour
    // overwrite leaves the count untouched.
    function automatic logic [COUNT_W-1:0] sat_step(input logic [COUNT_W-1:0] cnt,
                                                    input logic dec,
                                                    input logic inc);
        logic [COUNT_W-1:0] res;
        if (inc && !dec) begin
            res = (cnt >= COUNT_MAX) ? COUNT_MAX : cnt + 7'd1;
        end else if (dec && !inc) begin
            res = (cnt == 7'd0) ? 7'd0 : cnt - 7'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/board_piece_counter.sv
// Live black/white piece counters driven by the old and new value of each
// effective store write; both counts saturate at 0 and 64.
module board_piece_counter
    import board_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [1:0]         old_val,
    input  logic [1:0]         new_val,
    output logic [COUNT_W-1:0] black_count,
    output logic [COUNT_W-1:0] white_count
);

    logic [COUNT_W-1:0] black_r;
    logic [COUNT_W-1:0] white_r;
    logic [COUNT_W-1:0] black_s;
    logic [COUNT_W-1:0] white_s;

    // Next-count computation for the current write.
    always_comb begin
        black_s = black_r;
        white_s = white_r;
        if (we) begin
            black_s = sat_step(black_r, old_val == CELL_BLACK, new_val == CELL_BLACK);
            white_s = sat_step(white_r, old_val == CELL_WHITE, new_val == CELL_WHITE);
        end else begin
            black_s = black_r;
            white_s = white_r;
        end
    end

    // Count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            black_r <= 7'd0;
            white_r <= 7'd0;
        end else begin
            black_r <= black_s;
            white_r <= white_s;
        end
    end

    assign black_count = black_r;
    assign white_count = white_r;

endmodule

// File: rtl/board_mem_responder.sv
// Memory-side endpoint of the board-memory bus: 64x2 board store with a
// post-reset clear sweep, read-before-write responses routed per client.
module board_mem_responder
    import board_pkg::*;
#(
    parameter int CELLS   = BOARD_CELLS,
    parameter int ADDR_BITS = ADDR_W
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_in,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [1:0]           data_in,
    input  logic                 wren_in,
    input  logic [1:0]           owner_in,
    output logic                 busy,
    output logic [1:0]           rdata_out,
    output logic                 rvalid_init,
    output logic                 rvalid_vali,
    output logic                 rvalid_flip,
    output logic                 rvalid_vga,
    output logic [COUNT_W-1:0]   black_count,
    output logic [COUNT_W-1:0]   white_count
);

    localparam int PTR_W = $clog2(CELLS);
    localparam logic [ADDR_BITS-1:0] CELLS_A  = ADDR_BITS'(CELLS);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(CELLS - 1);

    resp_state_e      state_r;
    resp_state_e      state_s;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_s;
    logic [1:0]       cells_r [CELLS];
    logic [1:0]       rdata_r;
    logic [3:0]       rvalid_r;

    logic             in_range_s;
    logic [PTR_W-1:0] idx_s;
    logic [1:0]       old_s;
    logic             accept_s;
    logic             wr_eff_s;

    // State and clear-pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // Next state: sweep every cell once, then serve requests forever.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_CLEAR: begin
                ptr_s = ptr_r + 1'b1;
                if (ptr_r == LAST_PTR) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_s = ST_READY;
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = '0;
            end
        endcase
    end

    // Request decode and read-before-write lookup.
    always_comb begin
        in_range_s = (addr_in < CELLS_A);
        idx_s      = addr_in[PTR_W-1:0];
        if (in_range_s) begin
            old_s = cells_r[idx_s];
        end else begin
            old_s = CELL_EMPTY;
        end
        accept_s = (state_r == ST_READY) && req_in;
        wr_eff_s = accept_s && wren_in && in_range_s && (data_in != CELL_RSVD);
    end

    // Board store; the cells are not reset because the sweep clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_CLEAR) begin
                cells_r[ptr_r] <= CELL_EMPTY;
            end else if (wr_eff_s) begin
                cells_r[idx_s] <= data_in;
            end
        end
    end

    // Registered response: data holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r  <= CELL_EMPTY;
            rvalid_r <= 4'b0000;
        end else begin
            rvalid_r <= 4'b0000;
            if (accept_s) begin
                rdata_r  <= old_s;
                rvalid_r <= owner_onehot(owner_in);
            end
        end
    end

    board_piece_counter u_counter (
        .clk         (clk),
        .rst         (rst),
        .we          (wr_eff_s),
        .old_val     (old_s),
        .new_val     (data_in),
        .black_count (black_count),
        .white_count (white_count)
    );

    assign busy        = (state_r == ST_CLEAR);
    assign rdata_out   = rdata_r;
    assign rvalid_init = rvalid_r[0];
    assign rvalid_vali = rvalid_r[1];
    assign rvalid_flip = rvalid_r[2];
    assign rvalid_vga  = rvalid_r[3];

endmodule
